// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_pkg
// Description : Shared sizing constants and types for the SIMT register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int NLANES = 8;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/regfile_lane.sv
`default_nettype none
// ============================================================================
// Module      : regfile_lane
// Description : One lane's private register file: one write port, two gated
//               combinational read ports, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_lane
  import regbank_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int NREGS_P  = NREGS,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,     // active-high despite the name
  input  logic                we,
  input  logic [ADDR_W_P-1:0] waddr,
  input  logic [DATA_W_P-1:0] wdata,
  input  logic                re_0,
  input  logic [ADDR_W_P-1:0] raddr_0,
  output logic [DATA_W_P-1:0] rdata_0,
  input  logic                re_1,
  input  logic [ADDR_W_P-1:0] raddr_1,
  output logic [DATA_W_P-1:0] rdata_1
);

  logic [DATA_W_P-1:0] r_mem [NREGS_P];

  // Addresses beyond the populated register count neither store nor return data.
  logic w_waddr_ok;
  logic w_raddr_0_ok;
  logic w_raddr_1_ok;

  assign w_waddr_ok   = (32'(waddr)   < 32'(NREGS_P));
  assign w_raddr_0_ok = (32'(raddr_0) < 32'(NREGS_P));
  assign w_raddr_1_ok = (32'(raddr_1) < 32'(NREGS_P));

  // Storage: cleared asynchronously on reset, one enabled write per clock edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NREGS_P; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we && w_waddr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port 0: pre-edge contents, zero when disabled (no write bypass).
  always_comb begin
    rdata_0 = '0;
    if (re_0 && w_raddr_0_ok) begin
      rdata_0 = r_mem[raddr_0];
    end
  end

  // Read port 1: independent of port 0, same gating rules.
  always_comb begin
    rdata_1 = '0;
    if (re_1 && w_raddr_1_ok) begin
      rdata_1 = r_mem[raddr_1];
    end
  end

endmodule : regfile_lane
`default_nettype wire

// File: rtl/simd_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : simd_register_bank
// Description : Eight-lane SIMT register bank. Shared write/read addresses,
//               per-lane enables, flattened per-lane data ports.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_register_bank
  import regbank_pkg::*;
#(
  parameter int DATA_W = regbank_pkg::DATA_W,
  parameter int NREGS  = regbank_pkg::NREGS,
  parameter int ADDR_W = regbank_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,       // active-high asynchronous reset
  input  logic [7:0]        write_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [DATA_W-1:0] wdata_2,
  input  logic [DATA_W-1:0] wdata_3,
  input  logic [DATA_W-1:0] wdata_4,
  input  logic [DATA_W-1:0] wdata_5,
  input  logic [DATA_W-1:0] wdata_6,
  input  logic [DATA_W-1:0] wdata_7,
  input  logic [7:0]        read_en_0,
  input  logic [ADDR_W-1:0] raddr_0,
  input  logic [7:0]        read_en_1,
  input  logic [ADDR_W-1:0] raddr_1,
  output logic [DATA_W-1:0] rdata_0_0,
  output logic [DATA_W-1:0] rdata_0_1,
  output logic [DATA_W-1:0] rdata_0_2,
  output logic [DATA_W-1:0] rdata_0_3,
  output logic [DATA_W-1:0] rdata_0_4,
  output logic [DATA_W-1:0] rdata_0_5,
  output logic [DATA_W-1:0] rdata_0_6,
  output logic [DATA_W-1:0] rdata_0_7,
  output logic [DATA_W-1:0] rdata_1_0,
  output logic [DATA_W-1:0] rdata_1_1,
  output logic [DATA_W-1:0] rdata_1_2,
  output logic [DATA_W-1:0] rdata_1_3,
  output logic [DATA_W-1:0] rdata_1_4,
  output logic [DATA_W-1:0] rdata_1_5,
  output logic [DATA_W-1:0] rdata_1_6,
  output logic [DATA_W-1:0] rdata_1_7
);

  logic [DATA_W-1:0] w_wdata   [NLANES];
  logic [DATA_W-1:0] w_rdata_0 [NLANES];
  logic [DATA_W-1:0] w_rdata_1 [NLANES];

  // Gather the flat write-data ports into a lane-indexed array.
  assign w_wdata[0] = wdata_0;
  assign w_wdata[1] = wdata_1;
  assign w_wdata[2] = wdata_2;
  assign w_wdata[3] = wdata_3;
  assign w_wdata[4] = wdata_4;
  assign w_wdata[5] = wdata_5;
  assign w_wdata[6] = wdata_6;
  assign w_wdata[7] = wdata_7;

  // One private register file per lane; addresses are shared, enables sliced.
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    regfile_lane #(
      .DATA_W_P (DATA_W),
      .NREGS_P  (NREGS),
      .ADDR_W_P (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (write_en[g]),
      .waddr   (waddr),
      .wdata   (w_wdata[g]),
      .re_0    (read_en_0[g]),
      .raddr_0 (raddr_0),
      .rdata_0 (w_rdata_0[g]),
      .re_1    (read_en_1[g]),
      .raddr_1 (raddr_1),
      .rdata_1 (w_rdata_1[g])
    );
  end : g_lane

  // Scatter the lane-indexed read data back onto the flat output ports.
  assign rdata_0_0 = w_rdata_0[0];
  assign rdata_0_1 = w_rdata_0[1];
  assign rdata_0_2 = w_rdata_0[2];
  assign rdata_0_3 = w_rdata_0[3];
  assign rdata_0_4 = w_rdata_0[4];
  assign rdata_0_5 = w_rdata_0[5];
  assign rdata_0_6 = w_rdata_0[6];
  assign rdata_0_7 = w_rdata_0[7];
  assign rdata_1_0 = w_rdata_1[0];
  assign rdata_1_1 = w_rdata_1[1];
  assign rdata_1_2 = w_rdata_1[2];
  assign rdata_1_3 = w_rdata_1[3];
  assign rdata_1_4 = w_rdata_1[4];
  assign rdata_1_5 = w_rdata_1[5];
  assign rdata_1_6 = w_rdata_1[6];
  assign rdata_1_7 = w_rdata_1[7];

endmodule : simd_register_bank
`default_nettype wire

// File: tb/tb_simd_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_register_bank
// Description : Self-checking scoreboard bench for simd_register_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_register_bank;
  import regbank_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  write_en;
  reg_addr_t   waddr;
  reg_data_t   wdata [8];
  logic [7:0]  read_en_0;
  reg_addr_t   raddr_0;
  logic [7:0]  read_en_1;
  reg_addr_t   raddr_1;
  reg_data_t   rd0 [8];
  reg_data_t   rd1 [8];

  reg_data_t   model [8][16];
  reg_data_t   exp_q [$];
  int          n_checks;
  int          n_fail;

  simd_register_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata_0   (wdata[0]),
    .wdata_1   (wdata[1]),
    .wdata_2   (wdata[2]),
    .wdata_3   (wdata[3]),
    .wdata_4   (wdata[4]),
    .wdata_5   (wdata[5]),
    .wdata_6   (wdata[6]),
    .wdata_7   (wdata[7]),
    .read_en_0 (read_en_0),
    .raddr_0   (raddr_0),
    .read_en_1 (read_en_1),
    .raddr_1   (raddr_1),
    .rdata_0_0 (rd0[0]),
    .rdata_0_1 (rd0[1]),
    .rdata_0_2 (rd0[2]),
    .rdata_0_3 (rd0[3]),
    .rdata_0_4 (rd0[4]),
    .rdata_0_5 (rd0[5]),
    .rdata_0_6 (rd0[6]),
    .rdata_0_7 (rd0[7]),
    .rdata_1_0 (rd1[0]),
    .rdata_1_1 (rd1[1]),
    .rdata_1_2 (rd1[2]),
    .rdata_1_3 (rd1[3]),
    .rdata_1_4 (rd1[4]),
    .rdata_1_5 (rd1[5]),
    .rdata_1_6 (rd1[6]),
    .rdata_1_7 (rd1[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input reg_data_t act, input reg_data_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pops 16 expected words (port 0 lanes 0..7, then port 1 lanes 0..7).
  task automatic compare_outputs(input string tag);
    reg_data_t e;
    for (int l = 0; l < 8; l++) begin
      e = exp_q.pop_front();
      check_val($sformatf("%s_p0_l%0d", tag, l), rd0[l], e);
    end
    for (int l = 0; l < 8; l++) begin
      e = exp_q.pop_front();
      check_val($sformatf("%s_p1_l%0d", tag, l), rd1[l], e);
    end
  endtask

  // Drives both read ports and pushes expectations taken from the model.
  task automatic model_read(input string tag, input logic [7:0] en0, input reg_addr_t a0,
                            input logic [7:0] en1, input reg_addr_t a1);
    read_en_0 = en0; raddr_0 = a0;
    read_en_1 = en1; raddr_1 = a1;
    for (int l = 0; l < 8; l++) exp_q.push_back(en0[l] ? model[l][a0] : '0);
    for (int l = 0; l < 8; l++) exp_q.push_back(en1[l] ? model[l][a1] : '0);
    #1;
    compare_outputs(tag);
  endtask

  // One write edge; the model follows only when reset is released.
  task automatic do_write(input logic [7:0] en, input reg_addr_t a);
    @(negedge clk);
    write_en = en; waddr = a;
    @(posedge clk);
    if (!rst_n) begin
      for (int l = 0; l < 8; l++) if (en[l]) model[l][a] = wdata[l];
    end
    #1;
    write_en = 8'h00;
  endtask

  task automatic clear_model();
    for (int l = 0; l < 8; l++)
      for (int r = 0; r < 16; r++) model[l][r] = '0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b1; write_en = 8'h00; waddr = '0;
    read_en_0 = 8'h00; raddr_0 = '0; read_en_1 = 8'h00; raddr_1 = '0;
    for (int l = 0; l < 8; l++) wdata[l] = 32'hFFFF_0000 | l;
    clear_model();

    // Writes attempted during reset must be ignored.
    do_write(8'hFF, 4'd7);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // Every register reads zero out of reset, on both ports.
    for (int a = 0; a < 16; a++) begin
      for (int l = 0; l < 16; l++) exp_q.push_back('0);
      read_en_0 = 8'hFF; raddr_0 = reg_addr_t'(a);
      read_en_1 = 8'hFF; raddr_1 = reg_addr_t'(a);
      #1;
      compare_outputs($sformatf("reset_a%0d", a));
    end

    // All-lane random write/readback at every address.
    for (int a = 0; a < 16; a++) begin
      for (int it = 0; it < 100; it++) begin
        for (int l = 0; l < 8; l++) wdata[l] = $urandom;
        do_write(8'hFF, reg_addr_t'(a));
        model_read("wr_p0", 8'hFF, reg_addr_t'(a), 8'h00, 4'd0);
        @(posedge clk); #1;
        model_read("wr_p1", 8'h00, 4'd0, 8'hFF, reg_addr_t'(a));
        @(posedge clk); #1;
        model_read("wr_both", 8'hFF, reg_addr_t'(a), 8'hFF, reg_addr_t'(a));
      end
    end

    // Lane mask: only lanes 0..3 take the second write.
    for (int l = 0; l < 8; l++) wdata[l] = 32'hAAAA_0000 + l;
    do_write(8'hFF, 4'd3);
    for (int l = 0; l < 8; l++) wdata[l] = 32'h1234_5678;
    do_write(8'h0F, 4'd3);
    read_en_0 = 8'hFF; raddr_0 = 4'd3; read_en_1 = 8'hFF; raddr_1 = 4'd3;
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 8; l++) exp_q.push_back(l < 4 ? 32'h1234_5678 : 32'hAAAA_0000 + l);
    #1;
    compare_outputs("mask");

    // Read-enable gating on port 0 while port 1 reads fully.
    for (int l = 0; l < 8; l++) wdata[l] = 32'hDEAD_BEEF;
    do_write(8'hFF, 4'd5);
    read_en_0 = 8'h55; raddr_0 = 4'd5; read_en_1 = 8'hFF; raddr_1 = 4'd5;
    for (int l = 0; l < 8; l++) exp_q.push_back((l % 2 == 0) ? 32'hDEAD_BEEF : 32'h0);
    for (int l = 0; l < 8; l++) exp_q.push_back(32'hDEAD_BEEF);
    #1;
    compare_outputs("gate");

    // Dual-address read with a same-cycle write to the port-0 address.
    for (int l = 0; l < 8; l++) wdata[l] = 32'h1;
    do_write(8'hFF, 4'd1);
    for (int l = 0; l < 8; l++) wdata[l] = 32'h2;
    do_write(8'hFF, 4'd2);
    @(negedge clk);
    read_en_0 = 8'hFF; raddr_0 = 4'd1; read_en_1 = 8'hFF; raddr_1 = 4'd2;
    for (int l = 0; l < 8; l++) wdata[l] = 32'h9;
    write_en = 8'hFF; waddr = 4'd1;
    for (int l = 0; l < 8; l++) exp_q.push_back(32'h1);
    for (int l = 0; l < 8; l++) exp_q.push_back(32'h2);
    #1;
    compare_outputs("rw_before");
    @(posedge clk); #1;
    write_en = 8'h00;
    for (int l = 0; l < 8; l++) exp_q.push_back(32'h9);
    for (int l = 0; l < 8; l++) exp_q.push_back(32'h2);
    #1;
    compare_outputs("rw_after");

    // Reset asserted between edges clears everything before the next edge.
    rst_n = 1'b1;
    for (int l = 0; l < 16; l++) exp_q.push_back('0);
    #1;
    compare_outputs("midreset");
    clear_model();
    @(negedge clk);
    rst_n = 1'b0;
    model_read("post_reset", 8'hFF, 4'd5, 8'hFF, 4'd3);

    // First write after release lands on the next edge.
    for (int l = 0; l < 8; l++) wdata[l] = 32'h5A5A_0000 + l;
    do_write(8'hFF, 4'd15);
    model_read("after_release", 8'hFF, 4'd15, 8'hF0, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_simd_register_bank
`default_nettype wire

// File: doc/simd_register_bank.md
# simd_register_bank

Eight-lane SIMT general-purpose register bank: each lane owns a private file of 16 × 32-bit registers. All lanes share one write address and two read addresses, with per-lane enables on every port. It sits between decode/issue, which supplies the operand addresses, and the lane ALUs. It provides two operand reads per lane per cycle and one writeback per lane per cycle.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `NREGS`, default 16: registers per lane.
- `ADDR_W`, default 4: equals `$clog2(NREGS)`.
- Lane count is fixed at 8 because the port list is flattened per lane.

Ports (fields: name, direction, width, meaning):
- `clk` in 1: single clock; all writes on its rising edge.
- `rst_n` in 1: reset is asynchronous and active-high (port name per codebase convention; asserted = 1).
- `write_en` in 8: bit *l* enables the write of lane *l*.
- `waddr` in ADDR_W: write address, shared by all lanes.
- `wdata_0` … `wdata_7` in DATA_W: write data for lanes 0–7.
- `read_en_0` in 8: per-lane enable for read port 0.
- `raddr_0` in ADDR_W: port-0 address, shared by all lanes.
- `read_en_1` in 8: per-lane enable for read port 1.
- `raddr_1` in ADDR_W: port-1 address, shared by all lanes.
- `rdata_0_0` … `rdata_0_7` out DATA_W: port-0 data for lanes 0–7.
- `rdata_1_0` … `rdata_1_7` out DATA_W: port-1 data for lanes 0–7.

## Operation
- Storage: 8 lanes × NREGS × DATA_W flops. There is no hardwired-zero register; all 16 addresses are writable.
- Reset: while `rst_n`=1, every register clears to 0 immediately (asynchronous).
  - Writes are ignored during reset.
  - Because reads are combinational, outputs read 0 during reset.
- Write: at a rising `clk` with reset deasserted, each lane *l* with `write_en[l]`=1 stores `wdata_l` into `reg[l][waddr]`.
  - Lanes with enable 0 are unchanged.
- Read port p (0/1), lane l:
  - `rdata_p_l` = `reg[l][raddr_p]` when `read_en_p[l]`=1.
  - `rdata_p_l` = 0 when `read_en_p[l]`=0.
- Both ports are fully independent. They may read the same or different addresses in the same cycle, with any enable pattern.
- Same-cycle read/write to one address: the read returns the old value, with no write-through bypass. The new value is visible after the edge.

## Timing
- Read latency is zero (combinational from `raddr_p`/`read_en_p`/storage to `rdata`).
  - The path must settle within 2 ns of an input change in simulation; use no `#` delays.
- Write latency is one edge. Data written at edge N is readable combinationally right after edge N.
- Reset asserted mid-operation clears all lanes at once, regardless of `clk`. The first write after deassertion takes effect at the next rising edge.
- Address out of range (NREGS < 2^ADDR_W):
  - a read returns 0;
  - a write is dropped.

## Structure
- Package `regbank_pkg` holds:
  - `DATA_W`, `NREGS`, `ADDR_W`, `NLANES`=8;
  - typedefs `reg_addr_t` (logic [ADDR_W-1:0]) and `reg_data_t` (logic [DATA_W-1:0]).
- Sub-module `regfile_lane` is one lane's storage:
  - 1 write port (`we`, `waddr`, `wdata`);
  - 2 gated combinational read ports;
  - async reset.
- The top level instantiates `regfile_lane` 8 times via generate. It fans out the shared addresses, slices the enables, and maps the flat `wdata_*`/`rdata_*` ports.

## Test plan
- Reset: hold `rst_n`=1, then release, enable both reads at every address → every `rdata_*` = 0.
- All-lane write/readback:
  - For each addr 0–15, 100 iterations: `write_en`=8'hFF with random `wdata_0..7`, one edge.
  - Then `read_en_0`=8'hFF at that address → `rdata_0_l` = `wdata_l` within 2 ns.
  - Next cycle, port 1 alone → `rdata_1_l` = `wdata_l`.
  - Next cycle, both ports → both match.
- Lane mask: write addr 3 with 32'hAAAA_0000+l in all lanes, then `write_en`=8'h0F with 32'h1234_5678 → lanes 0–3 read 32'h1234_5678, lanes 4–7 read 32'hAAAA_0004…7.
- Read-enable gating: reg 5 holds 32'hDEAD_BEEF in all lanes, `read_en_0`=8'h55 → odd lanes 0, even lanes 32'hDEAD_BEEF; port 1 is unaffected.
- Dual-address read plus same-cycle write: reg1=32'h1, reg2=32'h2. `raddr_0`=1, `raddr_1`=2, and write reg1=32'h9 in the same cycle.
  - Before the edge: port 0 = 32'h1, port 1 = 32'h2.
  - After the edge: port 0 = 32'h9.
- Reset mid-run: registers loaded, assert `rst_n` between edges → all reads 0 immediately, before the next `clk` edge.
